apb_bus_master: RTL and testbench

//  Bridges the CPU data-bus port (busAddr/busWData/busRData) to an APB3 peripheral bus.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_addr_decoder.sv | 28 ++
 rtl/apb_bus_master.sv | 133 +++++++++++++
 tb/tb_apb_bus_master.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB bus master and its address decoder.
package apb_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

   localparam int APB_PAGE_BITS = 12;

   // Index width that stays legal (>=1 bit) even for a single slave.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational page decoder: maps a 4 KiB page number to a slave index and one-hot select.
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int          NUM_SLAVES = 4,
   parameter logic [19:0] BASE_PAGE  = 20'h10000,
   parameter int          IDX_W      = idx_width(NUM_SLAVES)
) (
   input  logic [31-APB_PAGE_BITS:0] addr_page,
   output logic                      hit,
   output logic [IDX_W-1:0]          index,
   output logic [NUM_SLAVES-1:0]     sel
);

   logic [31-APB_PAGE_BITS:0] page_offset;

   // Unsigned wrap makes pages below BASE_PAGE land far above NUM_SLAVES and miss.
   assign page_offset = addr_page - BASE_PAGE;
   assign hit         = page_offset < (32-APB_PAGE_BITS)'(NUM_SLAVES);
   assign index       = page_offset[IDX_W-1:0];

   generate
      for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_sel
         assign sel[gi] = hit && (page_offset == (32-APB_PAGE_BITS)'(gi));
      end
   endgenerate

endmodule

// File: rtl/apb_bus_master.sv
// CPU data-bus to APB3 bridge: latches one request, runs SETUP/ACCESS, returns a registered response.
module apb_bus_master
   import apb_pkg::*;
#(
   parameter int          NUM_SLAVES     = 4,
   parameter logic [19:0] BASE_PAGE      = 20'h10000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     transfer,
   input  logic                     write,
   input  logic [31:0]              addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata,
   output logic                     ready,
   output logic                     err,
   output logic [31:0]              PADDR,
   output logic [31:0]              PWDATA,
   output logic                     PWRITE,
   output logic                     PENABLE,
   output logic [NUM_SLAVES-1:0]    PSEL,
   input  logic [NUM_SLAVES*32-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]    PREADY
);

   localparam int IDX_W = idx_width(NUM_SLAVES);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   apb_state_e            state_reg, state_next;
   logic [31:0]           paddr_reg, pwdata_reg, rdata_reg;
   logic                  pwrite_reg, hit_reg, ready_reg, err_reg;
   logic [IDX_W-1:0]      index_reg;
   logic [NUM_SLAVES-1:0] psel_reg;
   logic [CNT_W-1:0]      cnt_reg;

   logic                  dec_hit;
   logic [IDX_W-1:0]      dec_index;
   logic [NUM_SLAVES-1:0] dec_sel;
   logic                  pready_sel, complete, complete_err;
   logic [31:0]           prdata_sel;

   apb_addr_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .BASE_PAGE  (BASE_PAGE),
      .IDX_W      (IDX_W)
   ) u_decoder (
      .addr_page (addr[31:APB_PAGE_BITS]),
      .hit       (dec_hit),
      .index     (dec_index),
      .sel       (dec_sel)
   );

   always_comb begin
      pready_sel = 1'b0;
      prdata_sel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (index_reg == IDX_W'(i)) begin
            pready_sel = PREADY[i];
            prdata_sel = PRDATA[32*i +: 32];
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      complete     = 1'b0;
      complete_err = 1'b0;
      case (state_reg)
         IDLE:    if (transfer) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS: begin
            // A selected slave's PREADY wins over the timeout on the final cycle.
            if (!hit_reg) begin
               complete     = 1'b1;
               complete_err = 1'b1;
            end else if (pready_sel) begin
               complete = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
               complete     = 1'b1;
               complete_err = 1'b1;
            end
            if (complete) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= IDLE;
         paddr_reg  <= '0;
         pwdata_reg <= '0;
         pwrite_reg <= 1'b0;
         hit_reg    <= 1'b0;
         index_reg  <= '0;
         psel_reg   <= '0;
         cnt_reg    <= '0;
         rdata_reg  <= '0;
         ready_reg  <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         ready_reg <= complete;
         err_reg   <= complete_err;
         if (state_reg == IDLE && transfer) begin
            paddr_reg  <= addr;
            pwdata_reg <= wdata;
            pwrite_reg <= write;
            hit_reg    <= dec_hit;
            index_reg  <= dec_index;
            psel_reg   <= dec_sel;
         end
         if (state_reg == ACCESS) begin
            if (complete)            cnt_reg <= '0;
            else if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
         end
         if (complete && !pwrite_reg) rdata_reg <= complete_err ? 32'h0 : prdata_sel;
      end
   end

   assign PADDR   = paddr_reg;
   assign PWDATA  = pwdata_reg;
   assign PWRITE  = pwrite_reg;
   assign PENABLE = (state_reg == ACCESS);
   assign PSEL    = (state_reg != IDLE) ? psel_reg : '0;
   assign rdata   = rdata_reg;
   assign ready   = ready_reg;
   assign err     = err_reg;

endmodule

// File: tb/tb_apb_bus_master.sv
// Directed and randomized transactions checked against a latency/response model of the bridge.
module tb_apb_bus_master;

   localparam int NS = 4;
   localparam logic [31:0] HIT_BASE = 32'h1000_0000;
   localparam logic [31:0] HIT_END  = 32'h1000_0000 + 32'(NS * 4096);

   logic          clk = 1'b0;
   logic          reset, transfer, write;
   logic [31:0]   addr, wdata, rdata;
   logic          ready, err;
   logic [31:0]   PADDR, PWDATA;
   logic          PWRITE, PENABLE;
   logic [NS-1:0] PSEL;
   logic [NS*32-1:0] PRDATA;
   logic [NS-1:0] PREADY;

   int tests  = 0;
   int failed = 0;
   logic [31:0] exp_rdata;

   always #5 clk = ~clk;

   apb_bus_master #(
      .NUM_SLAVES     (NS),
      .BASE_PAGE      (20'h10000),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .transfer (transfer),
      .write    (write),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ready    (ready),
      .err      (err),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PWRITE   (PWRITE),
      .PENABLE  (PENABLE),
      .PSEL     (PSEL),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Caller is at posedge+1 of cycle 0; returns at posedge+1 of the ready cycle with transfer low.
   task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input int w, input logic [31:0] sdata);
      bit hit;
      int idx, lat;
      logic exp_err;
      logic [NS-1:0] exp_psel;
      hit      = (a >= HIT_BASE) && (a < HIT_END);
      idx      = hit ? int'((a - HIT_BASE) >> 12) : 0;
      exp_psel = hit ? NS'(1 << idx) : '0;
      if (!hit)         begin lat = 3;     exp_err = 1'b1; end
      else if (w <= 15) begin lat = 3 + w; exp_err = 1'b0; end
      else              begin lat = 18;    exp_err = 1'b1; end
      for (int i = 0; i < NS; i++) PRDATA[32*i +: 32] = $urandom();
      if (hit) PRDATA[32*idx +: 32] = sdata;
      transfer = 1'b1; write = wr; addr = a; wdata = wd;
      PREADY   = NS'($urandom());
      if (hit) PREADY[idx] = 1'b0;
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         if (k < lat) begin
            transfer = 1'($urandom_range(0, 1));
            addr     = $urandom();
            write    = 1'($urandom_range(0, 1));
            wdata    = $urandom();
         end else begin
            transfer = 1'b0;
         end
         PREADY = NS'($urandom());
         if (hit) PREADY[idx] = (k >= 2 + w) || (k == 1 && $urandom_range(0, 1) == 1);
         check("ready", {31'b0, ready}, {31'b0, k == lat});
         check("psel", 32'(PSEL), (k < lat) ? 32'(exp_psel) : 32'h0);
         check("penable", {31'b0, PENABLE}, {31'b0, (k >= 2 && k < lat)});
         check("paddr", PADDR, a);
         check("pwdata", PWDATA, wd);
         check("pwrite", {31'b0, PWRITE}, {31'b0, wr});
      end
      if (!wr) exp_rdata = exp_err ? 32'h0 : sdata;
      check("err", {31'b0, err}, {31'b0, exp_err});
      check("rdata", rdata, exp_rdata);
      $display("[TB] txn %s addr=%h wdata=%h wait=%0d lat=%0d err=%0b rdata=%h",
               wr ? "WR" : "RD", a, wd, w, lat, err, rdata);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         PREADY = NS'($urandom());
         check("idle_ready", {31'b0, ready}, 32'h0);
         check("idle_psel", 32'(PSEL), 32'h0);
         check("idle_penable", {31'b0, PENABLE}, 32'h0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_psel"}, 32'(PSEL), 32'h0);
      check({tag, "_penable"}, {31'b0, PENABLE}, 32'h0);
      check({tag, "_pwrite"}, {31'b0, PWRITE}, 32'h0);
      check({tag, "_paddr"}, PADDR, 32'h0);
      check({tag, "_pwdata"}, PWDATA, 32'h0);
      check({tag, "_rdata"}, rdata, 32'h0);
      check({tag, "_ready"}, {31'b0, ready}, 32'h0);
      check({tag, "_err"}, {31'b0, err}, 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      reset = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
      PRDATA = '0; PREADY = '0; exp_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      idle_cycles(1);

      // Read hit, zero wait states.
      txn(1'b0, 32'h1000_1004, 32'h0, 0, 32'hDEAD_BEEF);
      idle_cycles(1);
      // Write with three wait states; rdata must keep DEAD_BEEF.
      txn(1'b1, 32'h1000_2000, 32'h0000_005A, 3, 32'h1234_5678);
      idle_cycles(1);
      // Decode miss.
      txn(1'b0, 32'h2000_0000, 32'h0, 0, 32'h0);
      idle_cycles(1);
      // Timeout on slave 0.
      txn(1'b0, 32'h1000_0000, 32'h0, 99, 32'hCAFE_F00D);
      idle_cycles(2);
      // Back-to-back: next transfer issued in the ready cycle.
      txn(1'b0, 32'h1000_3010, 32'h0, 1, 32'h0BAD_CAFE);
      txn(1'b0, 32'h1000_0020, 32'h0, 0, 32'h7777_0001);
      idle_cycles(1);

      // Reset in the middle of ACCESS: no completion pulse afterwards.
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_3008; wdata = 32'h0; PREADY = '0;
      @(posedge clk); #1;
      transfer = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pre_reset_penable", {31'b0, PENABLE}, 32'h1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_rdata = 32'h0;
      check_all_zero("midreset");
      idle_cycles(3);
      txn(1'b0, 32'h1000_3008, 32'h0, 2, 32'h4242_4242);
      idle_cycles(1);

      for (int n = 0; n < 40; n++) begin
         int sel, w;
         sel = int'($urandom_range(0, 5));
         if (sel < 4)       a = HIT_BASE + 32'(sel << 12) + ($urandom() & 32'hFFF);
         else if (sel == 4) a = {20'h0FFFF, 12'($urandom())};
         else               a = $urandom();
         w = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 5));
         txn(1'($urandom_range(0, 1)), a, $urandom(), w, $urandom());
         idle_cycles(int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
